// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ser_pkg
//  Description : Shared types and helpers for the bit_serializer_tx slice.
//                Holds the FSM state encoding and the bit-counter width
//                helper used by the top level.
//                Configuration macro: PARITY_EN (adds the ST_PARITY state).
//  Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

    // Frame sequencer states. ST_PARITY only exists when a parity bit is
    // appended to every frame.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } ser_state_e;

    // Width of the bit counter: it must be able to hold WIDTH itself, so
    // CNT_W = $clog2(WIDTH+1).
    function automatic int ser_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : ser_pkg
`default_nettype wire

// File: rtl/ser_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ser_hold_buf
//  Description : One-entry valid/ready holding register. A word is captured
//                when wr_valid_i && wr_ready_o; it is released by rd_take_i.
//                Capture is only possible while empty and release only while
//                full, so the two can never happen on the same edge.
//  Ports       : clk        - clock
//                rst        - asynchronous reset, active-high
//                wr_valid_i - write data valid
//                wr_ready_o - buffer empty, can accept (= !full_o)
//                wr_data_i  - write data
//                rd_take_i  - consumer takes the buffered word this edge
//                rd_data_o  - buffered word
//                full_o     - buffer holds a word
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_hold_buf
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_take_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (wr_valid_i && !full_q) begin
            data_q <= wr_data_i;
            full_q <= 1'b1;
        end else if (rd_take_i) begin
            full_q <= 1'b0;
        end
    end

    assign wr_ready_o = !full_q;
    assign rd_data_o  = data_q;
    assign full_o     = full_q;

endmodule : ser_hold_buf
`default_nettype wire

// File: rtl/bit_serializer_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer_tx
//  Description : Parallel-to-serial transmitter. Accepts WIDTH-bit words on a
//                valid/ready handshake, buffers one word while another
//                shifts, and emits one bit per clock edge with en=1, marking
//                the first and last bit of each frame.
//                Configuration macro: PARITY_EN - when defined each frame is
//                followed by an even-parity bit (frame = WIDTH+1 bits).
//  Parameters  : WIDTH     - data bits per frame (>= 2)
//                MSB_FIRST - 1: bit WIDTH-1 first, 0: bit 0 first
//                IDLE_BIT  - level on out while no frame is active
//  Ports       : clk         - clock
//                rst         - asynchronous reset, active-high
//                din         - parallel word to transmit
//                din_valid   - din is valid
//                din_ready   - hold buffer can accept a word
//                en          - bit strobe; bits advance only when en=1
//                out         - registered serial bit
//                out_valid   - one pulse per emitted bit
//                frame_start - asserted with the first bit of a frame
//                frame_end   - asserted with the last bit of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer_tx
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int               CNT_W         = ser_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Shift-order helpers: the bit leaving the shifter next, and the
    // shifter contents after that bit has left.
    // ------------------------------------------------------------------
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 1'b0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 1'b0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // ------------------------------------------------------------------
    // Hold buffer
    // ------------------------------------------------------------------
    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_take;

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (din_valid),
        .wr_ready_o (din_ready),
        .wr_data_i  (din),
        .rd_take_i  (w_take),
        .rd_data_o  (w_hold_data),
        .full_o     (w_hold_full)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             par_q,   par_d;
    logic             out_q,   out_d;
    logic             valid_q, valid_d;
    logic             fs_q,    fs_d;
    logic             fe_q,    fe_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            out_q   <= IDLE_BIT;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic. With en=0 everything holds and the
    // strobes drop, so a stalled bit is never reported twice.
    // A frame that ends returns to ST_IDLE, which reloads from the hold
    // buffer on the very next enabled edge: chained frames have no gap.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        out_d   = out_q;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        fe_d    = 1'b0;
        w_take  = 1'b0;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_hold_full) begin
                        w_take  = 1'b1;
                        out_d   = head_bit(w_hold_data);
                        shreg_d = shift_once(w_hold_data);
                        par_d   = head_bit(w_hold_data);
                        cnt_d   = CNT_W'(1);
                        valid_d = 1'b1;
                        fs_d    = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        out_d = IDLE_BIT;
                    end
                end

                ST_SHIFT: begin
                    out_d   = head_bit(shreg_q);
                    shreg_d = shift_once(shreg_q);
                    par_d   = par_q ^ head_bit(shreg_q);
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b1;
                    if (cnt_q == LAST_DATA_IDX) begin
`ifdef PARITY_EN
                        state_d = ST_PARITY;
`else
                        fe_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
`endif
                    end
                end

`ifdef PARITY_EN
                ST_PARITY: begin
                    // par_q now holds the XOR of all WIDTH data bits.
                    out_d   = par_q;
                    valid_d = 1'b1;
                    fe_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
`endif

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign out         = out_q;
    assign out_valid   = valid_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;

endmodule : bit_serializer_tx
`default_nettype wire

// File: tb/tb_bit_serializer_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serializer_tx
//  Description : Self-checking bench for bit_serializer_tx (WIDTH=8,
//                MSB_FIRST=1, IDLE_BIT=0). Honours PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer_tx;

    localparam int W         = 8;
    localparam bit MSB_FIRST = 1'b1;
    localparam bit IDLE_BIT  = 1'b0;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         en;
    logic         out;
    logic         out_valid;
    logic         frame_start;
    logic         frame_end;

    bit_serializer_tx #(
        .WIDTH     (W),
        .MSB_FIRST (MSB_FIRST),
        .IDLE_BIT  (IDLE_BIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .en          (en),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a frame is a list of bits; a word waits in a
    // one-deep hold slot until the current frame list is empty.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic b;
        logic fs;
        logic fe;
    } mbit_t;

    mbit_t        mq[$];
    logic         m_full;
    logic [W-1:0] m_hold;
    logic         e_out, e_valid, e_fs, e_fe;

    // i-th bit on the wire for word w (i = W is the even-parity bit)
    function automatic logic frame_bit(input logic [W-1:0] w, input int i);
        if (i >= W) return ^w;
        return MSB_FIRST ? w[W-1-i] : w[i];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_full  = 1'b0;
            e_out   = IDLE_BIT;
            e_valid = 1'b0;
            e_fs    = 1'b0;
            e_fe    = 1'b0;
        end else begin
            logic  acc;
            mbit_t x;
            acc     = din_valid && !m_full;
            e_valid = 1'b0;
            e_fs    = 1'b0;
            e_fe    = 1'b0;
            if (en) begin
                if (mq.size() == 0 && m_full) begin
                    for (int i = 0; i < FL; i++)
                        mq.push_back('{b: frame_bit(m_hold, i), fs: (i == 0), fe: (i == FL - 1)});
                    m_full = 1'b0;
                end
                if (mq.size() != 0) begin
                    x       = mq.pop_front();
                    e_out   = x.b;
                    e_valid = 1'b1;
                    e_fs    = x.fs;
                    e_fe    = x.fe;
                end else begin
                    e_out = IDLE_BIT;
                end
            end
            if (acc) begin
                m_hold = din;
                m_full = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare + statistics, sampled on the falling edge
    // ------------------------------------------------------------------
    bit           started = 1'b0;
    int           pulses, stall_viol, run, max_run, bitn, frames_done;
    logic [W-1:0] rx, last_word;
    int           last_len;

    initial begin
        pulses = 0; stall_viol = 0; run = 0; max_run = 0;
        bitn = 0; frames_done = 0; last_len = 0; rx = '0; last_word = '0;
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({out, out_valid, frame_start, frame_end, din_ready} !==
                {e_out, e_valid, e_fs, e_fe, !m_full}) begin
                errors++;
                $display("FAIL cycle_compare: got out=%b v=%b fs=%b fe=%b rdy=%b expected out=%b v=%b fs=%b fe=%b rdy=%b at %0t",
                         out, out_valid, frame_start, frame_end, din_ready,
                         e_out, e_valid, e_fs, e_fe, !m_full, $time);
            end
            if (out_valid) begin
                pulses++;
                if (!en) stall_viol++;
                run++;
                if (run > max_run) max_run = run;
                if (frame_start) bitn = 0;
                if (bitn < W) rx = {rx[W-2:0], out};
                bitn++;
                if (frame_end) begin
                    last_word = rx;
                    last_len  = bitn;
                    frames_done++;
                end
            end else begin
                run = 0;
            end
        end
    end

    // en driver: 0 = held high, 1 = toggling, 2 = random
    int en_mode = 0;
    always @(negedge clk) begin
        #1;
        case (en_mode)
            1:       en = ~en;
            2:       en = ($urandom_range(3) != 0);
            default: en = 1'b1;
        endcase
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        int k;
        din       = w;
        din_valid = 1'b1;
        k = 0;
        while (!din_ready && k < 400) begin
            cyc(1);
            k++;
        end
        if (k >= 400) chk("send_timeout", 32'd1, 32'd0);
        cyc(1);
        din_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            cyc(1);
            k++;
        end
        if (frames_done < target) chk("frame_timeout", frames_done, target);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        en        = 1'b1;

        // model pins: emission order and parity
        begin
            logic [W-1:0] v;
            for (int i = 0; i < W; i++) v[W-1-i] = frame_bit(8'hA5, i);
            chk("model_order_A5", v, 8'hA5);
            chk("model_parity_07", frame_bit(8'h07, W), 1);
            chk("model_parity_03", frame_bit(8'h03, W), 0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst     = 1'b0;
        started = 1'b1;
        cyc(1);
        chk("reset_out", out, IDLE_BIT);
        chk("reset_valid", out_valid, 0);
        chk("reset_ready", din_ready, 1);

        // single frame 8'hA5
        send(8'hA5);
        wait_frames(1, 50);
        chk("a5_word", last_word, 8'hA5);
        chk("a5_len", last_len, FL);
        cyc(2);
        chk("a5_idle_out", out, 1'b0);

        // back-to-back frames with no gap
        max_run = 0;
        send(8'hAA);
        send(8'h0F);
        wait_frames(3, 60);
        chk("chain_run", max_run, 2 * FL);
        chk("chain_word2", last_word, 8'h0F);

        // stalled bits with en toggling
        cyc(2);
        en_mode    = 1;
        pulses     = 0;
        stall_viol = 0;
        send(8'hC3);
        wait_frames(4, 80);
        cyc(4);
        chk("stall_pulses", pulses, FL);
        chk("stall_on_en0", stall_viol, 0);
        chk("stall_word", last_word, 8'hC3);
        en_mode = 0;
        cyc(2);

        // reset mid-frame with a word waiting in hold
        send(8'hFF);
        send(8'h55);
        begin
            int k;
            k = 0;
            while (!(out_valid && bitn == 4) && k < 40) begin
                cyc(1);
                k++;
            end
            chk("bit4_reached", bitn, 4);
        end
        rst = 1'b1;
        #1;
        chk("rst_out", out, 1'b0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", din_ready, 1);
        cyc(1);
        rst    = 1'b0;
        pulses = 0;
        cyc(30);
        chk("no_bits_after_rst", pulses, 0);

        // randomized traffic with random en and one mid-run reset
        en_mode = 2;
        for (int i = 0; i < 400; i++) begin
            din_valid = ($urandom_range(2) == 0);
            din       = W'($urandom);
            if (i == 200) rst = 1'b1;
            cyc(1);
            rst = 1'b0;
        end
        din_valid = 1'b0;
        en_mode   = 0;
        cyc(3 * FL);
        chk("drained_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bit_serializer_tx
`default_nettype wire
